// File: rtl/rect_mode_sequencer.sv
// Mode-select sequencer for the stereo rectification stage: the select changes only when
// both input streams are between frames and both output streams have drained.
module rect_mode_sequencer #(
  parameter int HEIGHT        = 480,
  parameter int INIT_MODE     = 1,
  parameter int DRAIN_TIMEOUT = 1048576,
  parameter int LW            = $clog2(HEIGHT + 1)
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [1:0] mode_req,
  input  logic       s_l_tvalid,
  input  logic       s_l_tready,
  input  logic       s_l_tlast,
  input  logic       s_l_tuser,
  input  logic       s_r_tvalid,
  input  logic       s_r_tready,
  input  logic       s_r_tlast,
  input  logic       s_r_tuser,
  input  logic       m_l_tvalid,
  input  logic       m_l_tready,
  input  logic       m_l_tlast,
  input  logic       m_l_tuser,
  input  logic       m_r_tvalid,
  input  logic       m_r_tready,
  input  logic       m_r_tlast,
  input  logic       m_r_tuser,
  output logic [1:0] mode_sel,
  output logic       hold_l,
  output logic       hold_r,
  output logic       mode_ack,
  output logic       busy,
  output logic       timeout_flag,
  output logic       bad_req_flag,
  output logic [1:0] state_dbg
);

  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    DRAIN  = 2'd2,
    SWITCH = 2'd3
  } state_t;

  state_t        state;
  logic [1:0]    target;
  logic [TW-1:0] drain_cnt;

  // Tap index: 0 = s_l, 1 = s_r, 2 = m_l, 3 = m_r.
  // A beat is tvalid & tready; these are passive taps, so there is no local handshake.
  logic [3:0]    tvalid;
  logic [3:0]    tready;
  logic [3:0]    tlast;
  logic [3:0]    tuser;
  logic [3:0]    beat;
  logic [3:0]    active;
  logic [LW-1:0] line_cnt [4];

  assign tvalid = {m_r_tvalid, m_l_tvalid, s_r_tvalid, s_l_tvalid};
  assign tready = {m_r_tready, m_l_tready, s_r_tready, s_l_tready};
  assign tlast  = {m_r_tlast,  m_l_tlast,  s_r_tlast,  s_l_tlast};
  assign tuser  = {m_r_tuser,  m_l_tuser,  s_r_tuser,  s_l_tuser};
  assign beat   = tvalid & tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      active <= '0;
      for (int i = 0; i < 4; i++) line_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (beat[i] && tuser[i]) begin
          // A start-of-frame always restarts the frame, even mid-frame.
          if (tlast[i] && (HEIGHT == 1)) begin
            active[i]   <= 1'b0;
            line_cnt[i] <= '0;
          end else begin
            active[i]   <= 1'b1;
            line_cnt[i] <= tlast[i] ? LW'(1) : '0;
          end
        end else if (beat[i] && tlast[i] && active[i]) begin
          if (line_cnt[i] == LW'(HEIGHT - 1)) begin
            active[i]   <= 1'b0;
            line_cnt[i] <= '0;
          end else begin
            line_cnt[i] <= line_cnt[i] + LW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= RUN;
      mode_sel     <= 2'(INIT_MODE);
      target       <= 2'(INIT_MODE);
      mode_ack     <= 1'b0;
      drain_cnt    <= '0;
      timeout_flag <= 1'b0;
      bad_req_flag <= 1'b0;
    end else begin
      mode_ack <= 1'b0;
      case (state)
        RUN: begin
          if (mode_req[1]) begin
            bad_req_flag <= 1'b1;
          end else if (mode_req != mode_sel) begin
            target <= mode_req;
            state  <= PEND;
          end
        end
        PEND: begin
          if (!active[0] && !active[1]) state <= DRAIN;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + TW'(1);
          // An idle output wins over the timeout, so a clean drain never raises the flag.
          if (!active[2] && !active[3]) begin
            state    <= SWITCH;
            mode_sel <= target;
            mode_ack <= 1'b1;
          end else if (drain_cnt == TW'(DRAIN_TIMEOUT - 1)) begin
            state        <= SWITCH;
            mode_sel     <= target;
            mode_ack     <= 1'b1;
            timeout_flag <= 1'b1;
          end
        end
        SWITCH: begin
          drain_cnt <= '0;
          state     <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign busy      = (state != RUN);
  assign hold_l    = busy && !active[0];
  assign hold_r    = busy && !active[1];
  assign state_dbg = state;

endmodule
